// File: rtl/tick_pkg.sv
// Shared types and default timing constants for the tick generator front end.
// Defaults assume a 50 MHz system clock.
package tick_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} set_state_t;

    localparam int DEF_DIV     = 50_000_000;
    localparam int DEF_DB_CYC  = 1_000_000;
    localparam int DEF_RPT_DLY = 25_000_000;
    localparam int DEF_RPT_PER = 5_000_000;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_gen_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer on the inverted (active-high)
// button, then a stability counter that flips db after DB_CYC steady cycles.
module debounce
    import tick_pkg::*;
#(
    parameter int DB_CYC = DEF_DB_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic db
);

    localparam int CW = cnt_w(DB_CYC);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            cnt  <= '0;
            db   <= 1'b0;
        end else begin
            sync <= {sync[0], ~raw_n};
            // Any sample that agrees with db restarts the stability window.
            if (sync[1] == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYC - 1)) begin
                db  <= ~db;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tick_gen.sv
// Timing source for the BCD counter chain: prescaled 1 Hz tick, replaced by
// debounced set pulses with auto-repeat while the set button is held.
module tick_gen
    import tick_pkg::*;
#(
    parameter int DIV     = DEF_DIV,
    parameter int DB_CYC  = DEF_DB_CYC,
    parameter int RPT_DLY = DEF_RPT_DLY,
    parameter int RPT_PER = DEF_RPT_PER
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic set_btn_n,
    output logic tick,
    output logic setting
);

    localparam int TW = cnt_w((RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER);
    localparam int PW = cnt_w(DIV);

    logic          db;
    set_state_t    state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic          set_pulse, norm_pulse;

    debounce #(.DB_CYC(DB_CYC)) u_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw_n (set_btn_n),
        .db    (db)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Release is tested before the terminal count so a release cycle never pulses.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        set_pulse = 1'b0;
        case (state)
            IDLE: begin
                if (db) begin
                    state_nxt = HOLD;
                    set_pulse = 1'b1;
                    timer_nxt = '0;
                end
            end
            HOLD: begin
                if (!db) begin
                    state_nxt = IDLE;
                end else if (timer == TW'(RPT_DLY - 1)) begin
                    state_nxt = REPEAT;
                    set_pulse = 1'b1;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            REPEAT: begin
                if (!db) begin
                    state_nxt = IDLE;
                end else if (timer == TW'(RPT_PER - 1)) begin
                    set_pulse = 1'b1;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Prescaler is held at zero whenever a set pulse can occur, including the
    // IDLE->HOLD cycle, so set and normal pulses can never collide.
    always_comb begin
        presc_nxt  = presc;
        norm_pulse = 1'b0;
        if (state != IDLE || state_nxt != IDLE) begin
            presc_nxt = '0;
        end else if (run) begin
            if (presc == PW'(DIV - 1)) begin
                presc_nxt  = '0;
                norm_pulse = 1'b1;
            end else begin
                presc_nxt = presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= '0;
            tick    <= 1'b0;
            setting <= 1'b0;
        end else begin
            presc   <= presc_nxt;
            tick    <= set_pulse | norm_pulse;
            setting <= (state_nxt != IDLE);
        end
    end

endmodule
